// File: rtl/chip_pkg.sv
// Shared definitions for the channel trigger/window capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chip_pkg;

  // Capture FSM states; ARM is the reset state and waits for pre-trigger fill.
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_CAPT = 2'd2
  } chip_state_e;

  // cfg_mode bit positions
  localparam int MODE_EDGE_BIT   = 0;  // 0 = level trigger, 1 = rising-edge trigger
  localparam int MODE_RETRIG_BIT = 1;  // 1 = trigger during a window extends it

  // Default window length for integrations that do not override cfg_len.
  localparam int LEN_CHIP = 4000;

endpackage

// File: rtl/chip_dly_line.sv
// Pre-trigger delay line: returns the sample tap_sel shifts older than din.
// Latency: combinational tap; history updates one cycle after each shift.
// Backpressure: none; history advances only when shift is high.
//
// Ports:
//   clk_sys, rst_n : clock, synchronous active-low reset (clears history)
//   din            : current sample
//   shift          : push din into history this cycle
//   tap_sel        : age of requested sample in shifts (0 = din itself)
//   dout           : selected sample
module chip_dly_line #(
  parameter int DW        = 16,
  parameter int PRE_DEPTH = 16,
  localparam int PW       = $clog2(PRE_DEPTH)
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          shift,
  input  logic [PW-1:0] tap_sel,
  output logic [DW-1:0] dout
);

  // hist[0] is the most recent shifted-in sample.
  logic [DW-1:0] hist [PRE_DEPTH];

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int i = 0; i < PRE_DEPTH; i++) hist[i] <= '0;
    end else if (shift) begin
      hist[0] <= din;
      for (int i = 1; i < PRE_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  always_comb begin
    if (tap_sel == '0) dout = din;
    else               dout = hist[tap_sel - 1'b1];
  end

endmodule

// File: rtl/chip_trig_path.sv
// Threshold trigger on a selected channel, emitting a delayed capture window.
// Latency: d1_* and busy are registered, one clk_sys after the causing sm_vld beat.
// Backpressure: none; sm_vld gaps stall the window, output has no ready.
//
// Ports:
//   clk_sys, rst_n         : clock, synchronous active-low reset
//   sm_data, sm_vld        : packed N_CH x DW samples, all valid together
//   cfg_en                 : enable; low aborts any window and re-arms
//   cfg_path_sel           : channel select (out of range -> channel 0)
//   cfg_chip_th            : unsigned trigger threshold
//   cfg_len                : window length in valid beats (0 treated as 1)
//   cfg_pre                : pre-trigger depth in valid beats
//   cfg_mode               : [0] edge trigger, [1] retrigger enable
//   d1_data/vld/sof/eof    : windowed output beats
//   busy                   : window in progress beyond its first beat
//   trig_cnt               : accepted window starts, saturating
module chip_trig_path
  import chip_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int DW        = 16,
  parameter int LW        = 20,
  parameter int PRE_DEPTH = 16,
  localparam int PW       = $clog2(PRE_DEPTH)
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] sm_data,
  input  logic               sm_vld,
  input  logic               cfg_en,
  input  logic [7:0]         cfg_path_sel,
  input  logic [DW-1:0]      cfg_chip_th,
  input  logic [LW-1:0]      cfg_len,
  input  logic [PW-1:0]      cfg_pre,
  input  logic [1:0]         cfg_mode,
  output logic [DW-1:0]      d1_data,
  output logic               d1_vld,
  output logic               d1_sof,
  output logic               d1_eof,
  output logic               busy,
  output logic [15:0]        trig_cnt
);

  localparam logic [LW-1:0] ONE_L = LW'(1);

  chip_state_e   state_q, state_n;
  logic [PW:0]   fill_q, fill_n;
  logic [LW-1:0] rem_q, rem_n;
  logic [LW-1:0] len_q, len_n;
  logic          retrig_q, retrig_n;
  logic [15:0]   cnt_n;
  logic [DW-1:0] data_n;
  logic          vld_n, sof_n, eof_n;

  logic [DW-1:0] d0, prev_q, tap;
  logic [LW-1:0] len_eff, reload;
  logic          trig;

  // Channel mux; anything out of range falls back to channel 0.
  always_comb begin
    d0 = sm_data[DW-1:0];
    for (int k = 1; k < N_CH; k++) begin
      if (cfg_path_sel == 8'(k)) d0 = sm_data[k*DW +: DW];
    end
  end

  // Previous valid sample for edge detection; cleared while disabled so the
  // first sample after enable can register as a rising edge.
  always_ff @(posedge clk_sys) begin
    if (!rst_n || !cfg_en) prev_q <= '0;
    else if (sm_vld)       prev_q <= d0;
  end

  chip_dly_line #(.DW(DW), .PRE_DEPTH(PRE_DEPTH)) u_dly (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     (d0),
    .shift   (sm_vld),
    .tap_sel (cfg_pre),
    .dout    (tap)
  );

  assign trig = sm_vld && (d0 >= cfg_chip_th) &&
                (!cfg_mode[MODE_EDGE_BIT] || (prev_q < cfg_chip_th));

  assign len_eff = (cfg_len == '0) ? ONE_L : cfg_len;

  // A retrigger beat counts as the first beat of the extended window. For a
  // 1-beat window one further beat is kept so the window still gets an eof.
  assign reload = (len_q == ONE_L) ? ONE_L : len_q - ONE_L;

  always_comb begin
    state_n  = state_q;
    fill_n   = fill_q;
    rem_n    = rem_q;
    len_n    = len_q;
    retrig_n = retrig_q;
    cnt_n    = trig_cnt;
    data_n   = '0;
    vld_n    = 1'b0;
    sof_n    = 1'b0;
    eof_n    = 1'b0;

    if (!cfg_en) begin
      state_n = ST_ARM;
      fill_n  = '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (sm_vld) fill_n = fill_q + 1'b1;
          if (fill_n >= {1'b0, cfg_pre}) begin
            state_n = ST_IDLE;
            fill_n  = '0;
          end
        end

        ST_IDLE: begin
          if (trig) begin
            vld_n    = 1'b1;
            sof_n    = 1'b1;
            data_n   = tap;
            len_n    = len_eff;
            retrig_n = cfg_mode[MODE_RETRIG_BIT];
            if (trig_cnt != 16'hFFFF) cnt_n = trig_cnt + 16'd1;
            if (len_eff == ONE_L) begin
              eof_n = 1'b1;
            end else begin
              state_n = ST_CAPT;
              rem_n   = len_eff - ONE_L;
            end
          end
        end

        ST_CAPT: begin
          if (sm_vld) begin
            vld_n  = 1'b1;
            data_n = tap;
            if (retrig_q && trig) begin
              rem_n = reload;
            end else if (rem_q <= ONE_L) begin
              // <= rather than == so a corrupted count can never stall here.
              eof_n   = 1'b1;
              state_n = ST_IDLE;
              rem_n   = '0;
            end else begin
              rem_n = rem_q - ONE_L;
            end
          end
        end

        default: state_n = ST_ARM;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q  <= ST_ARM;
      fill_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      retrig_q <= 1'b0;
      trig_cnt <= '0;
      d1_data  <= '0;
      d1_vld   <= 1'b0;
      d1_sof   <= 1'b0;
      d1_eof   <= 1'b0;
    end else begin
      state_q  <= state_n;
      fill_q   <= fill_n;
      rem_q    <= rem_n;
      len_q    <= len_n;
      retrig_q <= retrig_n;
      trig_cnt <= cnt_n;
      d1_data  <= data_n;
      d1_vld   <= vld_n;
      d1_sof   <= sof_n;
      d1_eof   <= eof_n;
    end
  end

  assign busy = (state_q == ST_CAPT);

endmodule
